// File: rtl/fan_pkg.sv
// Shared types and constants for the fan PWM driver: FSM state encoding,
// duty width and number of PWM slots per period.
package fan_pkg;

    localparam int DUTY_W    = 4;
    localparam int PWM_SLOTS = 16;

    localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RAMP = 2'd2,
        RUN  = 2'd3
    } fan_state_e;

endpackage

// File: rtl/fan_pwm_gen.sv
// PWM generator: prescaled 16-slot counter, duty latched at the period wrap
// so the compare level never changes inside a period.
module fan_pwm_gen
    import fan_pkg::*;
#(
    parameter int PWM_PRESC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty,
    output logic              fan_pwm
);

    localparam int SLOT_W  = $clog2(PWM_SLOTS);
    localparam int PRESC_W = $clog2(PWM_PRESC + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PWM_PRESC - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(PWM_SLOTS - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [SLOT_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [DUTY_W-1:0]  duty_lat_q, duty_lat_d;

    always_comb begin
        presc_d    = presc_q + 1'b1;
        pwm_cnt_d  = pwm_cnt_q;
        duty_lat_d = duty_lat_q;
        if (presc_q == PRESC_LAST) begin
            presc_d   = '0;
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            // New compare level takes effect exactly as slot 0 begins.
            if (pwm_cnt_q == SLOT_LAST) begin
                duty_lat_d = duty;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            duty_lat_q <= '0;
        end else begin
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_lat_q <= duty_lat_d;
        end
    end

    assign fan_pwm = (pwm_cnt_q < duty_lat_q);

endmodule

// File: rtl/fan_pwm_driver.sv
// Incubator fan driver: duty ramp FSM, heater/cooler interlock and PWM output.
// Define FAN_KICKSTART_EN to add a full-duty kick-start before ramping.
module fan_pwm_driver
    import fan_pkg::*;
#(
    parameter int PWM_PRESC   = 4,
    parameter int RAMP_DIV    = 8,
    parameter int KICK_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cooler,
    input  logic              heater,
    input  logic [DUTY_W-1:0] rps,
    output logic              fan_pwm,
    output logic              heater_en,
    output logic [DUTY_W-1:0] duty,
    output logic              fault,
    output fan_state_e        fan_state
);

    if (PWM_PRESC < 1 || RAMP_DIV < 1 || KICK_CYCLES < 1) begin : g_param_check
        $error("fan_pwm_driver: PWM_PRESC, RAMP_DIV and KICK_CYCLES must be >= 1");
    end

    localparam int STEP_W = $clog2(RAMP_DIV + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_DIV - 1);

    fan_state_e        state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              fault_q, fault_d;
    logic              heater_en_q, heater_en_d;
    logic [DUTY_W-1:0] tgt;

`ifdef FAN_KICKSTART_EN
    localparam int KICK_W = $clog2(KICK_CYCLES + 1);
    localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'(KICK_CYCLES - 1);
    logic [KICK_W-1:0] kick_q, kick_d;
`endif

    always_comb begin
        tgt         = (cooler && !fault_q) ? rps : '0;
        fault_d     = fault_q | (cooler & heater);
        heater_en_d = heater & ~cooler & ~fault_q;
        state_d     = state_q;
        duty_d      = duty_q;
        step_d      = step_q;
`ifdef FAN_KICKSTART_EN
        kick_d      = kick_q;
`endif
        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (tgt != '0) begin
`ifdef FAN_KICKSTART_EN
                    state_d = KICK;
                    duty_d  = DUTY_MAX;
                    kick_d  = '0;
`else
                    state_d = RAMP;
                    step_d  = '0;
`endif
                end
            end
`ifdef FAN_KICKSTART_EN
            KICK: begin
                if (tgt == '0 || kick_q == KICK_LAST) begin
                    state_d = RAMP;
                    step_d  = '0;
                    duty_d  = DUTY_MAX;
                end else begin
                    kick_d = kick_q + 1'b1;
                end
            end
`endif
            RAMP: begin
                // Direction is re-evaluated at every step, so a target change
                // redirects the ramp without disturbing the step timing.
                if (duty_q == tgt) begin
                    state_d = (tgt != '0) ? RUN : IDLE;
                end else if (step_q == STEP_LAST) begin
                    step_d = '0;
                    duty_d = (tgt > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            RUN: begin
                if (tgt != duty_q) begin
                    state_d = RAMP;
                    step_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            step_q      <= '0;
            fault_q     <= 1'b0;
            heater_en_q <= 1'b0;
`ifdef FAN_KICKSTART_EN
            kick_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            step_q      <= step_d;
            fault_q     <= fault_d;
            heater_en_q <= heater_en_d;
`ifdef FAN_KICKSTART_EN
            kick_q      <= kick_d;
`endif
        end
    end

    fan_pwm_gen #(
        .PWM_PRESC (PWM_PRESC)
    ) u_pwm_gen (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty_q),
        .fan_pwm (fan_pwm)
    );

    assign duty      = duty_q;
    assign fault     = fault_q;
    assign heater_en = heater_en_q;
    assign fan_state = state_q;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Bench for fan_pwm_driver: a per-clock reference model queues the expected
// outputs, and a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_fan_pwm_driver;
    import fan_pkg::*;

    localparam int P = 4;
    localparam int R = 8;
    localparam int K = 32;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cooler = 1'b0;
    logic       heater = 1'b0;
    logic [3:0] rps = 4'd0;
    logic       fan_pwm;
    logic       heater_en;
    logic [3:0] duty;
    logic       fault;
    fan_state_e fan_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    fan_pwm_driver #(
        .PWM_PRESC   (P),
        .RAMP_DIV    (R),
        .KICK_CYCLES (K)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cooler    (cooler),
        .heater    (heater),
        .rps       (rps),
        .fan_pwm   (fan_pwm),
        .heater_en (heater_en),
        .duty      (duty),
        .fault     (fault),
        .fan_state (fan_state)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_n counts active clocks since reset release; the PWM slot and the
    // period boundary fall straight out of that count.
    fan_state_e m_mode;
    int m_duty, m_step, m_kick, m_lat, m_n, m_tgt, m_old, m_slot;
    bit m_fault, m_heat;

    always @(posedge clk) begin
        if (!rst) begin
            m_mode = IDLE; m_duty = 0; m_step = 0; m_kick = 0;
            m_lat = 0; m_n = 0; m_fault = 0; m_heat = 0;
        end else begin
            m_tgt  = (cooler && !m_fault) ? int'(rps) : 0;
            m_old  = m_duty;
            m_heat = heater && !cooler && !m_fault;
            m_fault = m_fault || (cooler && heater);
            case (m_mode)
                IDLE: begin
                    m_duty = 0;
                    if (m_tgt > 0) begin
`ifdef FAN_KICKSTART_EN
                        m_mode = KICK; m_duty = 15; m_kick = 0;
`else
                        m_mode = RAMP; m_step = 0;
`endif
                    end
                end
                KICK: begin
                    if (m_tgt == 0 || m_kick == K - 1) begin
                        m_mode = RAMP; m_step = 0;
                    end else begin
                        m_kick++;
                    end
                end
                RAMP: begin
                    if (m_duty == m_tgt) begin
                        m_mode = (m_tgt != 0) ? RUN : IDLE;
                    end else begin
                        m_step++;
                        if (m_step == R) begin
                            m_step = 0;
                            m_duty += (m_tgt > m_duty) ? 1 : -1;
                        end
                    end
                end
                RUN: begin
                    if (m_duty != m_tgt) begin
                        m_mode = RAMP; m_step = 0;
                    end
                end
                default: m_mode = IDLE;
            endcase
            m_n++;
            if (m_n % (PWM_SLOTS * P) == 0) m_lat = m_old;
        end
        m_slot = (m_n / P) % PWM_SLOTS;
        exp_q.push_back({m_mode, 4'(m_duty), ((m_slot < m_lat) ? 1'b1 : 1'b0), m_heat, m_fault});
    end

    // ---------------- monitor ----------------
    logic [8:0] mon_exp;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("outputs{state,duty,pwm,heat,fault}",
                  16'({fan_state, duty, fan_pwm, heater_en, fault}), 16'(mon_exp));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_duty(input int v, input int budget, input string name);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (duty == 4'(v)) hit = 1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: duty=%0d never reached %0d within %0d cycles", name, duty, v, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", 16'({fan_state, duty, fan_pwm, heater_en, fault}), 16'd0);
        cooler = 1'b0; heater = 1'b0; rps = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int hi;
    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", 16'({fan_state, duty, fan_pwm, heater_en, fault}), 16'd0);
        rst = 1'b1;

        // Ramp up to 4 and hold; 4 of 16 slots high.
        cooler = 1'b1; rps = 4'd4;
        wait_duty(4, 400, "ramp_to_4");
        cycles(80);
        check("run_state_at_4", 16'(fan_state), 16'(RUN));
        hi = 0;
        for (int i = 0; i < PWM_SLOTS * P; i++) begin
            @(negedge clk);
            hi += int'(fan_pwm);
        end
        check("pwm_high_clocks_duty4", 16'(hi), 16'(4 * P));

        // Cooling off: ramp down to idle, output constant low.
        cooler = 1'b0;
        wait_duty(0, 100, "ramp_down_to_0");
        cycles(80);
        hi = 0;
        for (int i = 0; i < PWM_SLOTS * P; i++) begin
            @(negedge clk);
            hi += int'(fan_pwm);
        end
        check("pwm_high_clocks_idle", 16'(hi), 16'd0);
        check("idle_state", 16'(fan_state), 16'(IDLE));

`ifndef FAN_KICKSTART_EN
        // Redirect mid-ramp.
        cooler = 1'b1; rps = 4'd10;
        wait_duty(5, 200, "ramp_to_5");
        rps = 4'd2;
        wait_duty(2, 100, "redirect_to_2");
        cycles(20);
        check("run_at_2", 16'(fan_state), 16'(RUN));

        // Reset mid-ramp, then restart from 0.
        do_reset();
        cooler = 1'b1; rps = 4'd12;
        wait_duty(7, 200, "ramp_to_7");
        cycles(3);
        do_reset();
        cooler = 1'b1; rps = 4'd12;
        wait_duty(1, 40, "restart_from_0");
`else
        cooler = 1'b1; rps = 4'd3;
        wait_duty(3, 400, "kick_then_ramp_to_3");
        cycles(20);
        check("run_at_3", 16'(fan_state), 16'(RUN));
`endif

        // Interlock.
        do_reset();
        heater = 1'b1;
        cycles(2);
        check("heater_en_on", 16'(heater_en), 16'd1);
        heater = 1'b0; cooler = 1'b1; rps = 4'd6;
        wait_duty(6, 400, "ramp_to_6");
        cycles(2);
        heater = 1'b1;
        @(negedge clk);
        check("fault_set", 16'(fault), 16'd1);
        check("heater_en_off_on_fault", 16'(heater_en), 16'd0);
        heater = 1'b0;
        wait_duty(0, 100, "fault_ramp_down");
        cooler = 1'b0; heater = 1'b1;
        cycles(5);
        check("fault_sticky", 16'(fault), 16'd1);
        check("heater_blocked_by_fault", 16'(heater_en), 16'd0);

        // Randomized segments.
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            cooler = ($urandom_range(0, 3) != 0);
            rps    = 4'($urandom_range(0, 15));
            heater = ($urandom_range(0, 9) == 0);
            cycles($urandom_range(1, 90));
        end

        cycles(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
